dt_integrator: RTL and testbench

//  Converse of the dT estimator: rebuilds a temperature trajectory T (Q7.0) from a stream of dT samples.

---
 rtl/dt_integrator_if.sv | 28 ++
 rtl/dt_integrator.sv | 180 ++++++++++++++++++
 tb/tb_dt_integrator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dt_integrator_if.sv
// Handshake and control bundle between a dT source (master) and dt_integrator (slave).
interface dt_integrator_if;
  logic              init;
  logic              en;
  logic signed [7:0] T_init;
  logic signed [7:0] dT_in;
  logic              dt_valid;
  logic              dt_ready;
  logic        [7:0] k_dt;
  logic        [7:0] period;
  logic signed [7:0] t_min;
  logic signed [7:0] t_max;
  logic signed [7:0] T_out;
  logic              T_valid;
  logic              sat_hi;
  logic              sat_lo;
  logic              underrun;

  modport master (
    output init, en, T_init, dT_in, dt_valid, k_dt, period, t_min, t_max,
    input  dt_ready, T_out, T_valid, sat_hi, sat_lo, underrun
  );

  modport slave (
    input  init, en, T_init, dT_in, dt_valid, k_dt, period, t_min, t_max,
    output dt_ready, T_out, T_valid, sat_hi, sat_lo, underrun
  );
endinterface

// File: rtl/dt_integrator.sv
// Rebuilds a Q7.0 temperature trajectory by integrating buffered dT samples into a Q8.7 accumulator.
// Optional leak toward T_init is enabled by defining DTI_LEAK_EN.
module dt_integrator #(
  parameter int ACC_W   = 16,
  parameter int LEAK_SH = 6
) (
  input  logic           clk,
  input  logic           rst,
  dt_integrator_if.slave bus
);

  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  if (ACC_W < 16 || LEAK_SH < 0 || LEAK_SH >= ACC_W) begin : g_bad_param
    $error("dt_integrator: need ACC_W >= 16 and 0 <= LEAK_SH < ACC_W");
  end

  function automatic sum_t q7_to_sum(input logic signed [7:0] v);
    return {{(SUM_W-15){v[7]}}, v, 7'b0};
  endfunction

  function automatic sum_t clamp_to(input sum_t x, input sum_t lo, input sum_t hi);
    sum_t r;
    r = (x > hi) ? hi : x;
    return (r < lo) ? lo : r;
  endfunction

  // Round toward zero when dropping the 7 fraction bits.
  function automatic logic signed [7:0] trunc0(input acc_t x);
    acc_t t;
    t = x[ACC_W-1] ? x + ACC_W'(127) : x;
    return 8'(t >>> 7);
  endfunction

  state_t            state_q, state_d;
  acc_t              acc_q, acc_d;
  logic        [7:0] cnt_q, cnt_d;
  logic signed [7:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic signed [7:0] last_dt_q, last_dt_d;
  logic signed [7:0] t_out_q, t_out_d;
  logic              t_valid_q, t_valid_d;
  logic              sat_hi_q, sat_hi_d;
  logic              sat_lo_q, sat_lo_d;
  logic              underrun_q, underrun_d;

  logic        [7:0] period_eff;
  logic        [2:0] k_lim;
  logic              tick;
  logic              dt_ready;
  logic              accept;
  logic signed [7:0] d;
  acc_t              d_ext;
  acc_t              step;
  sum_t              lo_ext, hi_ext, init_ext;
  sum_t              sum, hi_cut, clamped, init_clamped;
  logic              clamp_hi, clamp_lo;

  always_comb begin
    period_eff = (bus.period == 8'd0) ? 8'd1 : bus.period;
    k_lim      = (bus.k_dt > 8'd7) ? 3'd7 : bus.k_dt[2:0];
    tick       = (state_q == RUN) && (cnt_q == period_eff - 8'd1);
    dt_ready   = (state_q != IDLE) && !bus.init && (!buf_full_q || tick);
    accept     = bus.dt_valid && dt_ready;

    d      = buf_full_q ? buf_q : last_dt_q;
    d_ext  = {{(ACC_W-15){d[7]}}, d, 7'b0};
    step   = d_ext >>> k_lim;
    lo_ext   = q7_to_sum(bus.t_min);
    hi_ext   = q7_to_sum(bus.t_max);
    init_ext = q7_to_sum(bus.T_init);

`ifdef DTI_LEAK_EN
    sum = sum_t'(acc_q) + sum_t'(step) - ((sum_t'(acc_q) - init_ext) >>> LEAK_SH);
`else
    sum = sum_t'(acc_q) + sum_t'(step);
`endif

    // Upper bound is applied first so an inverted window always lands on t_min.
    hi_cut       = (sum > hi_ext) ? hi_ext : sum;
    clamped      = (hi_cut < lo_ext) ? lo_ext : hi_cut;
    clamp_lo     = (hi_cut < lo_ext);
    clamp_hi     = (sum > hi_ext) && !clamp_lo;
    init_clamped = clamp_to(init_ext, lo_ext, hi_ext);
  end

  // NOTE: every *_d gets its hold value first so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    last_dt_d  = last_dt_q;
    t_out_d    = t_out_q;
    sat_hi_d   = sat_hi_q;
    sat_lo_d   = sat_lo_q;
    t_valid_d  = 1'b0;
    underrun_d = 1'b0;

    case (state_q)
      RUN:     if (!bus.en) state_d = PAUSE;
      PAUSE:   if (bus.en)  state_d = RUN;
      default: state_d = state_q;
    endcase

    if (state_q == RUN) cnt_d = tick ? 8'd0 : cnt_q + 8'd1;

    if (tick) begin
      last_dt_d  = d;
      buf_full_d = 1'b0;
      underrun_d = !buf_full_q;
      acc_d      = ACC_W'(clamped);
      t_out_d    = trunc0(ACC_W'(clamped));
      t_valid_d  = 1'b1;
      sat_hi_d   = clamp_hi;
      sat_lo_d   = clamp_lo;
    end

    if (accept) begin
      buf_d      = bus.dT_in;
      buf_full_d = 1'b1;
    end

    if (bus.init) begin
      state_d    = RUN;
      acc_d      = ACC_W'(init_clamped);
      t_out_d    = trunc0(ACC_W'(init_clamped));
      cnt_d      = 8'd0;
      buf_full_d = 1'b0;
      last_dt_d  = 8'sd0;
      t_valid_d  = 1'b0;
      sat_hi_d   = 1'b0;
      sat_lo_d   = 1'b0;
      underrun_d = 1'b0;
    end
  end

  // NOTE: state updates use <= so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the one-entry data buffer is reset too, keeping the datapath free of X after reset.
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      last_dt_q  <= '0;
      t_out_q    <= '0;
      t_valid_q  <= 1'b0;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      last_dt_q  <= last_dt_d;
      t_out_q    <= t_out_d;
      t_valid_q  <= t_valid_d;
      sat_hi_q   <= sat_hi_d;
      sat_lo_q   <= sat_lo_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.dt_ready = dt_ready;
  assign bus.T_out    = t_out_q;
  assign bus.T_valid  = t_valid_q;
  assign bus.sat_hi   = sat_hi_q;
  assign bus.sat_lo   = sat_lo_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_dt_integrator.sv
// Directed self-checking bench for dt_integrator: ramp, fractions, clamps, underrun, collisions, pause, reset.
module tb_dt_integrator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dt_integrator_if bus_if ();

  dt_integrator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic signed [31:0] observed,
                       input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_init(input string tag, input int t0, input int exp_t);
    bus_if.T_init = 8'(t0);
    bus_if.init   = 1'b1;
    step(1);
    bus_if.init   = 1'b0;
    check({tag, "_init_tout"}, bus_if.T_out, exp_t);
    check({tag, "_init_tvalid"}, bus_if.T_valid, 0);
  endtask

  // Waits out the gap of a tick period, then checks the tick outputs.
  task automatic tick_check(input string tag, input int gap, input int exp_t,
                            input int exp_u, input int exp_hi, input int exp_lo);
    step(gap - 1);
    check({tag, "_gap_tvalid"}, bus_if.T_valid, 0);
    check({tag, "_gap_underrun"}, bus_if.underrun, 0);
    step(1);
    check({tag, "_tvalid"}, bus_if.T_valid, 1);
    check({tag, "_tout"}, bus_if.T_out, exp_t);
    check({tag, "_underrun"}, bus_if.underrun, exp_u);
    check({tag, "_sat_hi"}, bus_if.sat_hi, exp_hi);
    check({tag, "_sat_lo"}, bus_if.sat_lo, exp_lo);
  endtask

  initial begin
    logic saw_valid;
    rst             = 1'b1;
    bus_if.init     = 1'b0;
    bus_if.en       = 1'b1;
    bus_if.T_init   = 8'sd0;
    bus_if.dT_in    = 8'sd0;
    bus_if.dt_valid = 1'b0;
    bus_if.k_dt     = 8'd0;
    bus_if.period   = 8'd4;
    bus_if.t_min    = -8'sd128;
    bus_if.t_max    = 8'sd127;
    step(2);
    check("rst_tout", bus_if.T_out, 0);
    check("rst_tvalid", bus_if.T_valid, 0);
    check("rst_sat_hi", bus_if.sat_hi, 0);
    check("rst_sat_lo", bus_if.sat_lo, 0);
    check("rst_underrun", bus_if.underrun, 0);
    check("rst_ready", bus_if.dt_ready, 0);
    rst = 1'b0;
    step(1);
    check("idle_ready", bus_if.dt_ready, 0);

    // Ramp: +3 per tick every 4 clocks
    bus_if.dT_in    = 8'sd3;
    bus_if.dt_valid = 1'b1;
    pulse_init("ramp", 20, 20);
    tick_check("ramp1", 4, 23, 0, 0, 0);
    tick_check("ramp2", 4, 26, 0, 0, 0);
    tick_check("ramp3", 4, 29, 0, 0, 0);

    // Fraction: k=2 gives +32 LSB per tick
    bus_if.k_dt  = 8'd2;
    bus_if.dT_in = 8'sd1;
    pulse_init("frac", 20, 20);
    tick_check("frac1", 4, 20, 0, 0, 0);
    tick_check("frac2", 4, 20, 0, 0, 0);
    tick_check("frac3", 4, 20, 0, 0, 0);
    tick_check("frac4", 4, 21, 0, 0, 0);

    // Saturation at t_max=30, then back down
    bus_if.k_dt  = 8'd0;
    bus_if.t_max = 8'sd30;
    bus_if.dT_in = 8'sd7;
    pulse_init("sat", 20, 20);
    tick_check("sat1", 4, 27, 0, 0, 0);
    tick_check("sat2", 4, 30, 0, 1, 0);
    step(3);
    bus_if.dT_in = -8'sd7;
    check("sat_hold_hi", bus_if.sat_hi, 1);
    check("sat_hold_tout", bus_if.T_out, 30);
    step(1);
    check("sat3_tout", bus_if.T_out, 30);
    check("sat3_hi", bus_if.sat_hi, 1);
    tick_check("sat4", 4, 23, 0, 0, 0);

    // Underrun: a single -2 sample, then zero-order hold
    bus_if.t_max    = 8'sd127;
    bus_if.dt_valid = 1'b0;
    pulse_init("und", 10, 10);
    bus_if.dT_in    = -8'sd2;
    bus_if.dt_valid = 1'b1;
    step(1);
    bus_if.dt_valid = 1'b0;
    tick_check("und1", 3, 8, 0, 0, 0);
    tick_check("und2", 4, 6, 1, 0, 0);
    tick_check("und3", 4, 4, 1, 0, 0);

    // Negative truncation toward zero, then live t_min clamp
    bus_if.k_dt     = 8'd1;
    bus_if.dT_in    = -8'sd1;
    bus_if.dt_valid = 1'b1;
    pulse_init("neg", 0, 0);
    tick_check("neg1", 4, 0, 0, 0, 0);
    tick_check("neg2", 4, -1, 0, 0, 0);
    bus_if.t_min = -8'sd1;
    tick_check("neg3", 4, -1, 0, 0, 1);

    // init collides with dt_valid: sample dropped, counter restarts
    bus_if.t_min    = -8'sd128;
    bus_if.k_dt     = 8'd0;
    bus_if.T_init   = 8'sd50;
    bus_if.dT_in    = 8'sd5;
    bus_if.dt_valid = 1'b1;
    bus_if.init     = 1'b1;
    #1;
    check("col_ready", bus_if.dt_ready, 0);
    step(1);
    bus_if.init     = 1'b0;
    bus_if.dt_valid = 1'b0;
    check("col_tout", bus_if.T_out, 50);
    check("col_sat_lo", bus_if.sat_lo, 0);
    tick_check("col1", 4, 50, 1, 0, 0);

    // Pause freezes the tick counter; inverted window resolves to t_min
    step(1);
    bus_if.en = 1'b0;
    step(1);
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      saw_valid = saw_valid | bus_if.T_valid;
    end
    check("pause_no_tick", saw_valid, 0);
    bus_if.t_min = 8'sd40;
    bus_if.t_max = 8'sd30;
    bus_if.en    = 1'b1;
    step(1);
    check("resume_a_tvalid", bus_if.T_valid, 0);
    step(1);
    check("resume_b_tvalid", bus_if.T_valid, 0);
    step(1);
    check("resume_tvalid", bus_if.T_valid, 1);
    check("inv_tout", bus_if.T_out, 40);
    check("inv_sat_lo", bus_if.sat_lo, 1);
    check("inv_sat_hi", bus_if.sat_hi, 0);

    // period=0 ticks every clock; k_dt=9 limits to 7
    bus_if.t_min    = -8'sd128;
    bus_if.t_max    = 8'sd127;
    bus_if.period   = 8'd0;
    bus_if.k_dt     = 8'd9;
    bus_if.dT_in    = -8'sd128;
    bus_if.dt_valid = 1'b1;
    pulse_init("p0", 0, 0);
    step(1);
    check("p0_1_tvalid", bus_if.T_valid, 1);
    check("p0_1_underrun", bus_if.underrun, 1);
    check("p0_1_tout", bus_if.T_out, 0);
    step(1);
    check("p0_2_tvalid", bus_if.T_valid, 1);
    check("p0_2_underrun", bus_if.underrun, 0);
    check("p0_2_tout", bus_if.T_out, -1);
    step(1);
    check("p0_3_tout", bus_if.T_out, -2);

    // Synchronous reset one clock before a tick
    bus_if.period = 8'd4;
    bus_if.k_dt   = 8'd0;
    bus_if.dT_in  = 8'sd3;
    pulse_init("mrst", 10, 10);
    step(3);
    rst = 1'b1;
    step(1);
    check("mrst_tout", bus_if.T_out, 0);
    check("mrst_tvalid", bus_if.T_valid, 0);
    check("mrst_underrun", bus_if.underrun, 0);
    check("mrst_ready", bus_if.dt_ready, 0);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      saw_valid = saw_valid | bus_if.T_valid;
    end
    check("mrst_idle_no_tick", saw_valid, 0);
    check("mrst_idle_tout", bus_if.T_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
